pass_requester: RTL and testbench

PASS_REQUESTER -- requirements
Module: pass_requester

---
 rtl/pass_requester.sv | 134 +++++++++++++
 tb/tb_pass_requester.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pass_requester.sv
// Lock pass requester: REQ -> CONF -> BACKOFF retry loop ending in GRANTED or FAIL.
// Optional macro PASS_SCAN_EN: each retry presents the next code (code + 1, mod 16).
module pass_requester #(
    parameter int MAX_TRIES   = 3,
    parameter int WAIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] key_in,
    input  logic       en_left,
    input  logic       en_right,
    output logic       request,
    output logic       confirm,
    output logic [3:0] passData,
    output logic       busy,
    output logic       granted,
    output logic       failed,
    output logic [2:0] attempts
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_CONF, S_BACKOFF, S_GRANTED, S_FAIL
    } state_t;

    state_t     state_reg;
    logic [3:0] code_reg;
    logic [3:0] conf_cnt_reg;
    logic       bo_cnt_reg;
    logic [3:0] retry_code;

`ifdef PASS_SCAN_EN
    assign retry_code = code_reg + 4'd1;
`else
    assign retry_code = code_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            code_reg     <= 4'd0;
            conf_cnt_reg <= 4'd0;
            bo_cnt_reg   <= 1'b0;
            request      <= 1'b0;
            confirm      <= 1'b0;
            passData     <= 4'd0;
            busy         <= 1'b0;
            granted      <= 1'b0;
            failed       <= 1'b0;
            attempts     <= 3'd0;
        end else if (abort) begin
            // attempts is deliberately kept so the caller can inspect it after an abort
            state_reg    <= S_IDLE;
            conf_cnt_reg <= 4'd0;
            bo_cnt_reg   <= 1'b0;
            request      <= 1'b0;
            confirm      <= 1'b0;
            passData     <= 4'd0;
            busy         <= 1'b0;
            granted      <= 1'b0;
            failed       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_FAIL: begin
                    if (start) begin
                        state_reg <= S_REQ;
                        code_reg  <= key_in;
                        attempts  <= 3'd0;
                        request   <= 1'b1;
                        confirm   <= 1'b0;
                        passData  <= key_in;
                        busy      <= 1'b1;
                        granted   <= 1'b0;
                        failed    <= 1'b0;
                    end
                end
                S_REQ: begin
                    state_reg    <= S_CONF;
                    conf_cnt_reg <= 4'd1;
                    confirm      <= 1'b1;
                end
                S_CONF: begin
                    // a grant seen on the last waiting cycle still wins over the timeout
                    if (en_left | en_right) begin
                        state_reg <= S_GRANTED;
                        busy      <= 1'b0;
                        granted   <= 1'b1;
                    end else if (conf_cnt_reg == 4'(WAIT_CYCLES)) begin
                        state_reg  <= S_BACKOFF;
                        bo_cnt_reg <= 1'b0;
                        request    <= 1'b0;
                        confirm    <= 1'b0;
                        if (attempts != 3'(MAX_TRIES))
                            attempts <= attempts + 3'd1;
                    end else begin
                        conf_cnt_reg <= conf_cnt_reg + 4'd1;
                    end
                end
                S_BACKOFF: begin
                    if (bo_cnt_reg) begin
                        conf_cnt_reg <= 4'd0;
                        if (attempts == 3'(MAX_TRIES)) begin
                            state_reg <= S_FAIL;
                            passData  <= 4'd0;
                            busy      <= 1'b0;
                            failed    <= 1'b1;
                        end else begin
                            state_reg <= S_REQ;
                            code_reg  <= retry_code;
                            passData  <= retry_code;
                            request   <= 1'b1;
                        end
                    end else begin
                        bo_cnt_reg <= 1'b1;
                    end
                end
                S_GRANTED: begin
                    state_reg <= S_GRANTED;
                end
                default: begin
                    state_reg <= S_IDLE;
                    request   <= 1'b0;
                    confirm   <= 1'b0;
                    passData  <= 4'd0;
                    busy      <= 1'b0;
                    granted   <= 1'b0;
                    failed    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pass_requester.sv
// Scoreboard bench for pass_requester: stimulus queues the expected outputs per cycle, a monitor checks them.
module tb_pass_requester;

    typedef struct packed {
        logic       request;
        logic       confirm;
        logic [3:0] pd;
        logic       busy;
        logic       granted;
        logic       failed;
        logic [2:0] att;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, abort, en_left, en_right;
    logic [3:0] key_in;
    logic       request, confirm, busy, granted, failed;
    logic [3:0] passData;
    logic [2:0] attempts;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    string name_q[$];

    localparam int WAIT = 4;

    pass_requester #(.MAX_TRIES(3), .WAIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .key_in(key_in),
        .en_left(en_left), .en_right(en_right), .request(request), .confirm(confirm),
        .passData(passData), .busy(busy), .granted(granted), .failed(failed),
        .attempts(attempts)
    );

    always #5 clk = ~clk;

    function automatic exp_t e_idle(input logic [2:0] a);
        return {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, a};
    endfunction
    function automatic exp_t e_req(input logic [3:0] c, input logic [2:0] a);
        return {1'b1, 1'b0, c, 1'b1, 1'b0, 1'b0, a};
    endfunction
    function automatic exp_t e_conf(input logic [3:0] c, input logic [2:0] a);
        return {1'b1, 1'b1, c, 1'b1, 1'b0, 1'b0, a};
    endfunction
    function automatic exp_t e_bo(input logic [3:0] c, input logic [2:0] a);
        return {1'b0, 1'b0, c, 1'b1, 1'b0, 1'b0, a};
    endfunction
    function automatic exp_t e_gr(input logic [3:0] c, input logic [2:0] a);
        return {1'b1, 1'b1, c, 1'b0, 1'b1, 1'b0, a};
    endfunction
    function automatic exp_t e_fail(input logic [2:0] a);
        return {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, a};
    endfunction

    // Code presented on retry round r (0-based) for a latched key k.
    function automatic logic [3:0] rc(input logic [3:0] k, input int r);
`ifdef PASS_SCAN_EN
        return k + 4'(r);
`else
        return k;
`endif
    endfunction

    task automatic cyc(input logic r, input logic s, input logic a, input logic [3:0] k,
                       input logic el, input logic er, input exp_t e, input string nm);
        reset = r; start = s; abort = a; key_in = k; en_left = el; en_right = er;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic tick(input exp_t e, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic round(input logic [3:0] c, input logic [2:0] a);
        for (int i = 0; i < WAIT; i++) tick(e_conf(c, a), "conf_wait");
        tick(e_bo(c, a + 3'd1), "backoff1");
        tick(e_bo(c, a + 3'd1), "backoff2");
    endtask

    task automatic fail_run(input logic [3:0] k);
        cyc(1'b0, 1'b1, 1'b0, k, 1'b0, 1'b0, e_req(k, 3'd0), "start_req");
        for (int r = 0; r < 3; r++) begin
            if (r > 0) tick(e_req(rc(k, r), 3'(r)), "retry_req");
            round(rc(k, r), 3'(r));
        end
        tick(e_fail(3'd3), "fail_enter");
        tick(e_fail(3'd3), "fail_hold");
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {request, confirm, passData, busy, granted, failed, attempts};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got req=%b conf=%b pd=%h busy=%b gr=%b fl=%b att=%0d, want req=%b conf=%b pd=%h busy=%b gr=%b fl=%b att=%0d",
                         nm, got.request, got.confirm, got.pd, got.busy, got.granted, got.failed, got.att,
                         e.request, e.confirm, e.pd, e.busy, e.granted, e.failed, e.att);
            end else begin
                $display("ok   %s: req=%b conf=%b pd=%h busy=%b gr=%b fl=%b att=%0d",
                         nm, got.request, got.confirm, got.pd, got.busy, got.granted, got.failed, got.att);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; key_in = 4'd0; en_left = 1'b0; en_right = 1'b0;
        @(negedge clk);

        // Reset held two cycles, then released
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, e_idle(3'd0), "reset1");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, e_idle(3'd0), "reset2");
        tick(e_idle(3'd0), "idle_after_reset");

        // Grant on the second CONF cycle; GRANTED ignores en_* afterwards
        cyc(1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, e_req(4'hB, 3'd0), "g_req");
        tick(e_conf(4'hB, 3'd0), "g_conf1");
        tick(e_conf(4'hB, 3'd0), "g_conf2");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, e_gr(4'hB, 3'd0), "g_granted");
        tick(e_gr(4'hB, 3'd0), "g_hold");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, e_idle(3'd0), "g_abort");

        // No grant: three rounds then FAIL; restart from FAIL with F to see code wrap under scan
        fail_run(4'hB);
        fail_run(4'hF);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, e_idle(3'd3), "fail_abort");

        // abort + start together during CONF with attempts=1
        cyc(1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, e_req(4'h5, 3'd0), "a_req");
        round(4'h5, 3'd0);
        tick(e_req(rc(4'h5, 1), 3'd1), "a_retry_req");
        tick(e_conf(rc(4'h5, 1), 3'd1), "a_conf");
        cyc(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, e_idle(3'd1), "a_abort_start");
        tick(e_idle(3'd1), "a_idle_hold");

        // Grant on the exact timeout cycle; start in CONF ignored
        cyc(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, e_req(4'h3, 3'd0), "t_req");
        tick(e_conf(4'h3, 3'd0), "t_conf1");
        cyc(1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, e_conf(4'h3, 3'd0), "t_conf2_start_ign");
        tick(e_conf(4'h3, 3'd0), "t_conf3");
        tick(e_conf(4'h3, 3'd0), "t_conf4");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, e_gr(4'h3, 3'd0), "t_grant_at_timeout");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, e_idle(3'd0), "t_abort");

        // Reset mid-sequence beats abort and start
        cyc(1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, e_req(4'hA, 3'd0), "r_req");
        round(4'hA, 3'd0);
        tick(e_req(rc(4'hA, 1), 3'd1), "r_retry_req");
        cyc(1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, e_idle(3'd0), "r_reset_mid");
        tick(e_idle(3'd0), "r_idle_hold");

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
